// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: round-robin issue of FP add/sub/mul requests onto one
// shared fadd pipe and one shared fmul pipe (fixed latency LAT), with an
// in-flight track pipe and a credit-protected result FIFO.
// Optional build macro FPU_ARB_STATS_EN adds add/mul/stall statistics counters.
`timescale 1ns/1ps
module fpu_issue_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = $clog2(NREQ),
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*2-1:0]    req_op,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  output logic [31:0]          fa_x1,
  output logic [31:0]          fa_x2,
  input  logic [31:0]          fa_y,
  output logic [31:0]          fm_x1,
  output logic [31:0]          fm_x2,
  input  logic [31:0]          fm_y,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [31:0]          res_data,
  output logic                 res_err
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [31:0]          stat_add_cnt,
  output logic [31:0]          stat_mul_cnt,
  output logic [31:0]          stat_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LAT + 2);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            grant_found;
  logic [NREQ-1:0] grant_vec;
  logic            can_issue;
  logic            accept;
  logic [1:0]      sel_op;
  logic [31:0]     sel_x1;
  logic [31:0]     sel_x2;

  logic            trk_v  [0:LAT];
  logic [ID_W-1:0] trk_id [0:LAT];
  logic [1:0]      trk_op [0:LAT];
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   occupancy;

  logic [ID_W-1:0] mem_id   [0:DEPTH-1];
  logic [31:0]     mem_data [0:DEPTH-1];
  logic            mem_err  [0:DEPTH-1];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic            full;
  logic            push;
  logic            pop;
  logic            push_err;
  logic [31:0]     push_data;

  // Count valid track stages; a same-cycle pop is deliberately not credited.
  always_comb begin
    inflight = '0;
    for (int s = 0; s <= LAT; s++) begin
      inflight = inflight + CW'(trk_v[s]);
    end
  end

  assign occupancy = CW'(count) + inflight;
  // Gating with rstn keeps req_ready low while reset is asserted.
  assign can_issue = rstn && (occupancy < CW'(DEPTH));

  // Round-robin search starting at ptr; at most one grant per cycle.
  always_comb begin
    grant_vec   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    if (can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = ID_W'((int'(ptr) + k) % NREQ);
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
      if (grant_found) grant_vec[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant_vec;
  assign accept    = grant_found;
  assign sel_op    = req_op[int'(grant_idx) * 2 +: 2];
  assign sel_x1    = req_x1[int'(grant_idx) * 32 +: 32];
  assign sel_x2    = req_x2[int'(grant_idx) * 32 +: 32];
  assign ptr_next  = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  // Pointer advance and operand loading on the accept edge; idle unit holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr   <= '0;
      fa_x1 <= '0;
      fa_x2 <= '0;
      fm_x1 <= '0;
      fm_x2 <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
      case (sel_op)
        OP_ADD: begin
          fa_x1 <= sel_x1;
          fa_x2 <= sel_x2;
        end
        OP_SUB: begin
          fa_x1 <= sel_x1;
          fa_x2 <= {~sel_x2[31], sel_x2[30:0]};
        end
        OP_MUL: begin
          fm_x1 <= sel_x1;
          fm_x2 <= sel_x2;
        end
        default: ;
      endcase
    end
  end

  // Track pipe: s0 captures the acceptance, then shifts in lockstep with the units.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s <= LAT; s++) begin
        trk_v[s]  <= 1'b0;
        trk_id[s] <= '0;
        trk_op[s] <= '0;
      end
    end else begin
      trk_v[0]  <= accept;
      trk_id[0] <= grant_idx;
      trk_op[0] <= sel_op;
      for (int s = 1; s <= LAT; s++) begin
        trk_v[s]  <= trk_v[s-1];
        trk_id[s] <= trk_id[s-1];
        trk_op[s] <= trk_op[s-1];
      end
    end
  end

  assign push      = trk_v[LAT];
  assign push_err  = (trk_op[LAT] == OP_RSV);
  assign push_data = push_err      ? 32'h0 :
                     trk_op[LAT][1] ? fm_y : fa_y;
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign full      = (count == (AW+1)'(DEPTH));
  assign res_id    = mem_id[rptr];
  assign res_data  = mem_data[rptr];
  assign res_err   = mem_err[rptr];

  // Result FIFO: circular buffer, head entry drives the res_* outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        mem_id[e]   <= '0;
        mem_data[e] <= '0;
        mem_err[e]  <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_id[wptr]   <= trk_id[LAT];
        mem_data[wptr] <= push_data;
        mem_err[wptr]  <= push_err;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full));

`ifdef FPU_ARB_STATS_EN
  // Free-running statistics, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_add_cnt   <= '0;
      stat_mul_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (accept && !sel_op[1])       stat_add_cnt   <= stat_add_cnt + 1'b1;
      if (accept && sel_op == OP_MUL) stat_mul_cnt   <= stat_mul_cnt + 1'b1;
      if (|req_valid && !accept)      stat_stall_cnt <= stat_stall_cnt + 1'b1;
    end
  end
`endif

endmodule
